mult_pipe_gen: RTL and testbench
================================

Name: mult_pipe_gen

Overview:
Parametrised, fully pipelined integer multiply functional unit for the R10K execute stage, successor to the fixed 4-stage unsigned low-half multiplier. Generalised in operand width, stage count and result mode (low, unsigned-high, signed-high, signed×unsigned-high). Carries ROB index, PRF destination tag and branch mask per stage. Supports valid/ready backpressure from the CDB arbiter and branch-mask squash.

Parameters:
XLEN  64  operand/result width
NUM_STAGE  4  pipeline stages; XLEN % NUM_STAGE must be 0, else elaboration error
ROB_W  5  ROB index width
PRF_W  6  PRF tag width
BM_W  4  branch-mask width (one bit per in-flight branch)

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-high reset
valid_i  in  1  issue valid
ready_o  out  1  unit can accept this cycle
opa_i  in  XLEN  multiplicand
opb_i  in  XLEN  multiplier
mode_i  in  2  0=MUL low, 1=MULHU, 2=MULH (s×s), 3=MULHSU (a signed, b unsigned)
rob_idx_i  in  ROB_W  ROB index
dest_tag_i  in  PRF_W  destination PRF tag
bmask_i  in  BM_W  branch dependence mask
br_done_i  in  1  branch resolved this cycle
br_mispred_i  in  1  resolved branch mispredicted
br_tag_i  in  BM_W  one-hot tag of resolved branch
flush_i  in  1  kill every in-flight op
valid_o  out  1  result valid
ready_i  in  1  CDB accepts result
result_o  out  XLEN  result
rob_idx_o  out  ROB_W  ROB index of result
dest_tag_o  out  PRF_W  PRF tag of result
bmask_o  out  BM_W  current branch mask of result

Behaviour:
- Stage k (0..NUM_STAGE-1) consumes multiplier bits [(k+1)*C-1 : k*C], C=XLEN/NUM_STAGE, adds partial product to a 2*XLEN accumulator; operands pre-extended to XLEN+1 bits per mode (signed → sign-extend, unsigned → zero) so the 2*XLEN accumulator holds the exact product mod 2^(2*XLEN).
- result_o = acc[XLEN-1:0] for mode 0, acc[2*XLEN-1:XLEN] otherwise. Exact for all operand values incl. most-negative.
- Each stage register holds: valid, acc, shifted mcand/mplier, mode, rob_idx, dest_tag, bmask. Metadata travels with data (no single shared tag register).
- Latency: accepted at edge t → valid_o high after edge t+NUM_STAGE if no stall. Throughput 1/cycle.
- Stall: stall = valid_o & ~ready_i. While stall, every stage holds. ready_o = ~stall. Accept = valid_i & ready_o. Bubbles do not collapse (global stall).
- Outputs registered from final stage; result_o/rob_idx_o/dest_tag_o/bmask_o stable while valid_o & ~ready_i.
- Branch resolve (br_done_i), applied to every stage incl. the op being accepted that cycle, and applied even while stalled:
  - mispredict: entries with (bmask & br_tag_i)!=0 have valid cleared next edge.
  - correct: br_tag_i bit cleared in every entry's bmask.
- flush_i: all valids cleared next edge; incoming op dropped; ready_o unaffected.
- A squashed final entry drops valid_o next cycle regardless of ready_i; CDB must not complete it.
- reset (sync): all stage valids 0, valid_o 0, result_o 0, rob_idx_o 0, dest_tag_o 0, bmask_o 0. Reset mid-operation discards everything. Datapath registers other than valid/outputs need no reset.
- reset has priority over flush_i, which has priority over branch resolve, which has priority over stall/advance.

Test Plan:
- Mode 0, opa=3, opb=5, ready_i=1 → valid_o after 4 cycles, result_o=15, rob_idx/dest_tag echoed.
- Back-to-back: 4 ops (0xFFFF_FFFF_FFFF_FFFF×2, mode 1 → 1; mode 0 → 0xFFFF_FFFF_FFFF_FFFE; mode 2 → 0xFFFF_FFFF_FFFF_FFFF; mode 3 → 0xFFFF_FFFF_FFFF_FFFF) → four consecutive results in order, one per cycle.
- Signed corner: mode 2, opa=opb=0x8000_0000_0000_0000 → 0x4000_0000_0000_0000; mode 0 same operands → 0.
- Backpressure: hold ready_i=0 for 3 cycles with pipe full → ready_o=0, outputs stable, no loss/duplication; release → 4 results in order.
- Branch: ops with bmask 0001, 0010, 0000 in flight; br_done_i, br_mispred_i=1, br_tag_i=0001 → first op never appears; then correct resolve tag 0010 → second op emerges with bmask_o=0000.
- Reset and flush mid-stream with 3 ops in flight → valid_o stays 0; next op issued after returns correct result with latency 4.

Source files
------------

// File: rtl/mult_pipe_gen.sv
// Pipelined integer multiplier for the execute stage: MUL / MULHU / MULH / MULHSU.
// Latency NUM_STAGE cycles from the accepting edge to valid_o; one op per cycle.
// Backpressure: valid_o & ~ready_i freezes every stage and drops ready_o.
//
// Ports:
//   clock, reset            clock and synchronous active-high reset
//   valid_i / ready_o       issue handshake
//   opa_i, opb_i, mode_i    operands and result mode (0 low, 1 hu, 2 h ss, 3 h su)
//   rob_idx_i, dest_tag_i   tags carried alongside the op
//   bmask_i                 branch dependence mask of the op
//   br_done_i, br_mispred_i, br_tag_i   branch resolution broadcast
//   flush_i                 kill everything in flight
//   valid_o / ready_i       result handshake towards the CDB
//   result_o, rob_idx_o, dest_tag_o, bmask_o   registered result and tags
module mult_pipe_gen #(
   parameter int XLEN      = 64,
   parameter int NUM_STAGE = 4,
   parameter int ROB_W     = 5,
   parameter int PRF_W     = 6,
   parameter int BM_W      = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [XLEN-1:0]  opa_i,
   input  logic [XLEN-1:0]  opb_i,
   input  logic [1:0]       mode_i,
   input  logic [ROB_W-1:0] rob_idx_i,
   input  logic [PRF_W-1:0] dest_tag_i,
   input  logic [BM_W-1:0]  bmask_i,
   input  logic             br_done_i,
   input  logic             br_mispred_i,
   input  logic [BM_W-1:0]  br_tag_i,
   input  logic             flush_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [XLEN-1:0]  result_o,
   output logic [ROB_W-1:0] rob_idx_o,
   output logic [PRF_W-1:0] dest_tag_o,
   output logic [BM_W-1:0]  bmask_o
);

   localparam int C   = XLEN / NUM_STAGE;   // multiplier bits consumed per stage
   localparam int AW  = 2 * XLEN;           // accumulator width
   localparam int PPW = XLEN + C + 3;       // exact width of one signed partial product

   generate
      if (XLEN % NUM_STAGE != 0) begin : g_bad_cfg
         $error("mult_pipe_gen: XLEN must be a multiple of NUM_STAGE");
      end
   endgenerate

   // Stage registers. r_mplier[k] is the multiplier already shifted so that
   // its low C bits are the chunk stage k consumed.
   logic             r_vld    [NUM_STAGE];
   logic [AW-1:0]    r_acc    [NUM_STAGE];
   logic [XLEN:0]    r_mcand  [NUM_STAGE];
   logic [XLEN:0]    r_mplier [NUM_STAGE];
   logic [1:0]       r_mode   [NUM_STAGE];
   logic [ROB_W-1:0] r_rob    [NUM_STAGE];
   logic [PRF_W-1:0] r_tag    [NUM_STAGE];
   logic [BM_W-1:0]  r_bm     [NUM_STAGE];

   logic             r_vld_o;
   logic [XLEN-1:0]  r_result;
   logic [ROB_W-1:0] r_rob_o;
   logic [PRF_W-1:0] r_tag_o;
   logic [BM_W-1:0]  r_bm_o;

   logic             w_stall, w_accept, w_kill_en, w_clr_en;
   logic             w_src_vld    [NUM_STAGE];
   logic [AW-1:0]    w_src_acc    [NUM_STAGE];
   logic [XLEN:0]    w_src_mcand  [NUM_STAGE];
   logic [XLEN:0]    w_src_mplier [NUM_STAGE];
   logic [1:0]       w_src_mode   [NUM_STAGE];
   logic [ROB_W-1:0] w_src_rob    [NUM_STAGE];
   logic [PRF_W-1:0] w_src_tag    [NUM_STAGE];
   logic [BM_W-1:0]  w_src_bm     [NUM_STAGE];
   logic [AW-1:0]    w_acc_nxt    [NUM_STAGE];
   logic             w_sel_vld    [NUM_STAGE];
   logic [BM_W-1:0]  w_sel_bm     [NUM_STAGE];
   logic             w_osel_vld;
   logic [BM_W-1:0]  w_osel_bm;
   logic [XLEN-1:0]  w_result;

   assign w_stall   = r_vld_o & ~ready_i;
   assign ready_o   = ~w_stall;
   assign w_accept  = valid_i & ~w_stall;
   assign w_kill_en = br_done_i & br_mispred_i;
   assign w_clr_en  = br_done_i & ~br_mispred_i;

   genvar k;
   generate
      for (k = 0; k < NUM_STAGE; k++) begin : g_stage
         logic [C+1:0]          w_chunk;
         logic signed [PPW-1:0] w_pp;

         if (k == 0) begin : g_head
            // One extra operand bit holds the sign (or zero) extension for the mode.
            assign w_src_vld[k]    = w_accept;
            assign w_src_acc[k]    = '0;
            assign w_src_mcand[k]  = {mode_i[1] & opa_i[XLEN-1], opa_i};
            assign w_src_mplier[k] = {(mode_i == 2'd2) & opb_i[XLEN-1], opb_i};
            assign w_src_mode[k]   = mode_i;
            assign w_src_rob[k]    = rob_idx_i;
            assign w_src_tag[k]    = dest_tag_i;
            assign w_src_bm[k]     = bmask_i;
         end else begin : g_body
            assign w_src_vld[k]    = r_vld[k-1];
            assign w_src_acc[k]    = r_acc[k-1];
            assign w_src_mcand[k]  = r_mcand[k-1];
            assign w_src_mplier[k] = r_mplier[k-1] >> C;
            assign w_src_mode[k]   = r_mode[k-1];
            assign w_src_rob[k]    = r_rob[k-1];
            assign w_src_tag[k]    = r_tag[k-1];
            assign w_src_bm[k]     = r_bm[k-1];
         end

         // Lower chunks are unsigned digits; the top chunk also owns the
         // extension bit and therefore carries the multiplier's sign weight.
         if (k == NUM_STAGE - 1) begin : g_top_chunk
            assign w_chunk = {w_src_mplier[k][C], w_src_mplier[k][C:0]};
         end else begin : g_low_chunk
            assign w_chunk = {2'b00, w_src_mplier[k][C-1:0]};
         end

         assign w_pp         = PPW'($signed(w_src_mcand[k])) * PPW'($signed(w_chunk));
         assign w_acc_nxt[k] = w_src_acc[k] + (AW'(w_pp) << (k * C));

         // A stalled stage re-evaluates its own entry so branch kills still land.
         assign w_sel_vld[k] = w_stall ? r_vld[k] : w_src_vld[k];
         assign w_sel_bm[k]  = w_stall ? r_bm[k]  : w_src_bm[k];
      end
   endgenerate

   assign w_osel_vld = w_stall ? r_vld_o : r_vld[NUM_STAGE-1];
   assign w_osel_bm  = w_stall ? r_bm_o  : r_bm[NUM_STAGE-1];
   assign w_result   = (r_mode[NUM_STAGE-1] == 2'd0) ? r_acc[NUM_STAGE-1][XLEN-1:0]
                                                     : r_acc[NUM_STAGE-1][AW-1:XLEN];

   // Control: valids and branch masks. Reset beats flush beats branch beats stall.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < NUM_STAGE; i++) begin
            r_vld[i] <= 1'b0;
            r_bm[i]  <= '0;
         end
         r_vld_o  <= 1'b0;
         r_result <= '0;
         r_rob_o  <= '0;
         r_tag_o  <= '0;
         r_bm_o   <= '0;
      end else begin
         for (int i = 0; i < NUM_STAGE; i++) begin
            r_vld[i] <= ~flush_i & w_sel_vld[i] & ~(w_kill_en & (|(w_sel_bm[i] & br_tag_i)));
            r_bm[i]  <= w_clr_en ? (w_sel_bm[i] & ~br_tag_i) : w_sel_bm[i];
         end
         r_vld_o <= ~flush_i & w_osel_vld & ~(w_kill_en & (|(w_osel_bm & br_tag_i)));
         r_bm_o  <= w_clr_en ? (w_osel_bm & ~br_tag_i) : w_osel_bm;
         if (!w_stall) begin
            r_result <= w_result;
            r_rob_o  <= r_rob[NUM_STAGE-1];
            r_tag_o  <= r_tag[NUM_STAGE-1];
         end
      end
   end

   // Datapath: no reset needed, qualified by the stage valids.
   always_ff @(posedge clock) begin
      if (!w_stall) begin
         for (int i = 0; i < NUM_STAGE; i++) begin
            r_acc[i]    <= w_acc_nxt[i];
            r_mcand[i]  <= w_src_mcand[i];
            r_mplier[i] <= w_src_mplier[i];
            r_mode[i]   <= w_src_mode[i];
            r_rob[i]    <= w_src_rob[i];
            r_tag[i]    <= w_src_tag[i];
         end
      end
   end

   assign valid_o    = r_vld_o;
   assign result_o   = r_result;
   assign rob_idx_o  = r_rob_o;
   assign dest_tag_o = r_tag_o;
   assign bmask_o    = r_bm_o;

endmodule

// File: tb/tb_mult_pipe_gen.sv
// Directed-vector bench for mult_pipe_gen (XLEN=64, NUM_STAGE=4).
// Each task drives one scenario and compares outputs 1 time unit after the edge.
// Expected values are hand-computed constants in each task.
module tb_mult_pipe_gen;

   logic        clock;
   logic        reset;
   logic        valid_i;
   logic        ready_o;
   logic [63:0] opa_i;
   logic [63:0] opb_i;
   logic [1:0]  mode_i;
   logic [4:0]  rob_idx_i;
   logic [5:0]  dest_tag_i;
   logic [3:0]  bmask_i;
   logic        br_done_i;
   logic        br_mispred_i;
   logic [3:0]  br_tag_i;
   logic        flush_i;
   logic        valid_o;
   logic        ready_i;
   logic [63:0] result_o;
   logic [4:0]  rob_idx_o;
   logic [5:0]  dest_tag_o;
   logic [3:0]  bmask_o;

   int errors = 0;
   int checks = 0;

   mult_pipe_gen dut (
      .clock(clock), .reset(reset),
      .valid_i(valid_i), .ready_o(ready_o),
      .opa_i(opa_i), .opb_i(opb_i), .mode_i(mode_i),
      .rob_idx_i(rob_idx_i), .dest_tag_i(dest_tag_i), .bmask_i(bmask_i),
      .br_done_i(br_done_i), .br_mispred_i(br_mispred_i), .br_tag_i(br_tag_i),
      .flush_i(flush_i),
      .valid_o(valid_o), .ready_i(ready_i),
      .result_o(result_o), .rob_idx_o(rob_idx_o), .dest_tag_o(dest_tag_o), .bmask_o(bmask_o)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic drive_op(input logic [63:0] a, input logic [63:0] b, input logic [1:0] m,
                           input logic [4:0] rob, input logic [5:0] tag, input logic [3:0] bm);
      valid_i    = 1'b1;
      opa_i      = a;
      opb_i      = b;
      mode_i     = m;
      rob_idx_i  = rob;
      dest_tag_i = tag;
      bmask_i    = bm;
   endtask

   task automatic idle();
      valid_i      = 1'b0;
      br_done_i    = 1'b0;
      br_mispred_i = 1'b0;
      br_tag_i     = 4'b0;
      flush_i      = 1'b0;
   endtask

   task automatic test_reset();
      idle();
      ready_i = 1'b1;
      opa_i = '0; opb_i = '0; mode_i = '0; rob_idx_i = '0; dest_tag_i = '0; bmask_i = '0;
      reset = 1'b1;
      step();
      step();
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
      checks++; if (result_o !== 64'h0) begin errors++; $display("FAIL reset_result: got %h expected 0", result_o); end
      checks++; if (rob_idx_o !== 5'h0) begin errors++; $display("FAIL reset_rob: got %h expected 0", rob_idx_o); end
      checks++; if (dest_tag_o !== 6'h0) begin errors++; $display("FAIL reset_tag: got %h expected 0", dest_tag_o); end
      checks++; if (bmask_o !== 4'h0) begin errors++; $display("FAIL reset_bmask: got %h expected 0", bmask_o); end
      reset = 1'b0;
      #1;
      checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready_o); end
   endtask

   task automatic test_basic();
      drive_op(64'd3, 64'd5, 2'd0, 5'd5, 6'd9, 4'd0);
      step();
      idle();
      for (int i = 1; i <= 3; i++) begin
         step();
         checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL basic_early_valid cyc%0d: got %b expected 0", i, valid_o); end
      end
      step();
      checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", valid_o); end
      checks++; if (result_o !== 64'd15) begin errors++; $display("FAIL basic_result: got %h expected f", result_o); end
      checks++; if (rob_idx_o !== 5'd5) begin errors++; $display("FAIL basic_rob: got %0d expected 5", rob_idx_o); end
      checks++; if (dest_tag_o !== 6'd9) begin errors++; $display("FAIL basic_tag: got %0d expected 9", dest_tag_o); end
      step();
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL basic_drain: got %b expected 0", valid_o); end
   endtask

   task automatic test_back_to_back();
      logic [1:0]  m_t [4];
      logic [63:0] e_t [4];
      m_t = '{2'd1, 2'd0, 2'd2, 2'd3};
      e_t = '{64'h1, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
      for (int c = 0; c < 8; c++) begin
         if (c < 4) drive_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, m_t[c], 5'(c + 1), 6'(c + 10), 4'd0);
         else idle();
         step();
         if (c >= 4) begin
            checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL b2b_valid op%0d: got %b expected 1", c - 4, valid_o); end
            checks++; if (result_o !== e_t[c-4]) begin errors++; $display("FAIL b2b_result op%0d: got %h expected %h", c - 4, result_o, e_t[c-4]); end
            checks++; if (rob_idx_o !== 5'(c - 3)) begin errors++; $display("FAIL b2b_rob op%0d: got %0d expected %0d", c - 4, rob_idx_o, c - 3); end
         end
      end
      step();
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b expected 0", valid_o); end
   endtask

   task automatic test_corner();
      logic [63:0] a_t [12];
      logic [63:0] b_t [12];
      logic [1:0]  m_t [12];
      logic [63:0] e_t [12];
      a_t = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
              64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234_5678_9ABC_DEF0,
              64'h1234_5678_9ABC_DEF0, 64'h0000_0001_0000_0001, 64'h0000_0001_0000_0001,
              64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
      b_t = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
              64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h10,
              64'h10, 64'h0000_0001_0000_0001, 64'h0000_0001_0000_0001,
              64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
      m_t = '{2'd2, 2'd0, 2'd3, 2'd1, 2'd2, 2'd0, 2'd1, 2'd1, 2'd0, 2'd3, 2'd1, 2'd2};
      e_t = '{64'h4000_0000_0000_0000, 64'h0, 64'hC000_0000_0000_0000,
              64'h7FFF_FFFF_FFFF_FFFF, 64'h0, 64'h2345_6789_ABCD_EF00,
              64'h1, 64'h1, 64'h0000_0002_0000_0001,
              64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0};
      for (int c = 0; c < 16; c++) begin
         if (c < 12) drive_op(a_t[c], b_t[c], m_t[c], 5'(c), 6'(c), 4'd0);
         else idle();
         step();
         if (c >= 4) begin
            checks++; if (valid_o !== 1'b1 || rob_idx_o !== 5'(c - 4)) begin errors++; $display("FAIL corner_seq op%0d: got valid=%b rob=%0d expected valid=1 rob=%0d", c - 4, valid_o, rob_idx_o, c - 4); end
            checks++; if (result_o !== e_t[c-4]) begin errors++; $display("FAIL corner_result op%0d: got %h expected %h", c - 4, result_o, e_t[c-4]); end
         end
      end
      step();
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL corner_drain: got %b expected 0", valid_o); end
   endtask

   task automatic test_backpressure();
      for (int c = 0; c < 4; c++) begin
         drive_op(64'(10 + c), 64'd3, 2'd0, 5'(c + 1), 6'd1, 4'd0);
         step();
      end
      idle();
      step();
      checks++; if (valid_o !== 1'b1 || rob_idx_o !== 5'd1 || result_o !== 64'd30) begin errors++; $display("FAIL bp_first: got valid=%b rob=%0d res=%0d expected 1/1/30", valid_o, rob_idx_o, result_o); end
      ready_i = 1'b0;
      // An op offered while stalled must not be taken.
      drive_op(64'd99, 64'd99, 2'd0, 5'd31, 6'd31, 4'd0);
      #1;
      checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready_low: got %b expected 0", ready_o); end
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (valid_o !== 1'b1 || rob_idx_o !== 5'd1 || result_o !== 64'd30) begin errors++; $display("FAIL bp_hold cyc%0d: got valid=%b rob=%0d res=%0d expected 1/1/30", i, valid_o, rob_idx_o, result_o); end
         checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready_hold cyc%0d: got %b expected 0", i, ready_o); end
      end
      idle();
      ready_i = 1'b1;
      #1;
      checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL bp_ready_release: got %b expected 1", ready_o); end
      for (int j = 1; j < 4; j++) begin
         step();
         checks++; if (valid_o !== 1'b1 || rob_idx_o !== 5'(j + 1) || result_o !== 64'(30 + 3 * j)) begin errors++; $display("FAIL bp_drain op%0d: got valid=%b rob=%0d res=%0d expected 1/%0d/%0d", j, valid_o, rob_idx_o, result_o, j + 1, 30 + 3 * j); end
      end
      for (int i = 0; i < 4; i++) begin
         step();
         checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL bp_no_extra cyc%0d: got valid=%b rob=%0d expected 0", i, valid_o, rob_idx_o); end
      end
   endtask

   task automatic test_branch();
      drive_op(64'd2, 64'd3, 2'd0, 5'd1, 6'd1, 4'b0001); step();
      drive_op(64'd4, 64'd5, 2'd0, 5'd2, 6'd2, 4'b0010); step();
      drive_op(64'd6, 64'd7, 2'd0, 5'd3, 6'd3, 4'b0000); step();
      idle();
      br_done_i = 1'b1; br_mispred_i = 1'b1; br_tag_i = 4'b0001;
      step();
      br_done_i = 1'b1; br_mispred_i = 1'b0; br_tag_i = 4'b0010;
      step();
      idle();
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL br_squash: got valid=%b rob=%0d expected 0", valid_o, rob_idx_o); end
      step();
      checks++; if (valid_o !== 1'b1 || rob_idx_o !== 5'd2 || result_o !== 64'd20) begin errors++; $display("FAIL br_second: got valid=%b rob=%0d res=%0d expected 1/2/20", valid_o, rob_idx_o, result_o); end
      checks++; if (bmask_o !== 4'b0000) begin errors++; $display("FAIL br_bmask_clr: got %b expected 0000", bmask_o); end
      step();
      checks++; if (valid_o !== 1'b1 || rob_idx_o !== 5'd3 || result_o !== 64'd42) begin errors++; $display("FAIL br_third: got valid=%b rob=%0d res=%0d expected 1/3/42", valid_o, rob_idx_o, result_o); end
      step();
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL br_drain: got %b expected 0", valid_o); end
   endtask

   task automatic test_branch_accept();
      // The op being accepted is killed by a mispredict on its own branch.
      drive_op(64'd8, 64'd8, 2'd0, 5'd4, 6'd4, 4'b0100);
      br_done_i = 1'b1; br_mispred_i = 1'b1; br_tag_i = 4'b0100;
      step();
      idle();
      drive_op(64'd9, 64'd9, 2'd0, 5'd5, 6'd5, 4'b0000);
      step();
      idle();
      step(); step(); step();
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL bra_killed: got valid=%b rob=%0d expected 0", valid_o, rob_idx_o); end
      step();
      checks++; if (valid_o !== 1'b1 || rob_idx_o !== 5'd5 || result_o !== 64'd81) begin errors++; $display("FAIL bra_next: got valid=%b rob=%0d res=%0d expected 1/5/81", valid_o, rob_idx_o, result_o); end
      step();
   endtask

   task automatic test_branch_stall();
      drive_op(64'd11, 64'd11, 2'd0, 5'd6, 6'd6, 4'b1000);
      step();
      idle();
      step(); step(); step(); step();
      checks++; if (valid_o !== 1'b1 || rob_idx_o !== 5'd6 || result_o !== 64'd121 || bmask_o !== 4'b1000) begin errors++; $display("FAIL brs_out: got valid=%b rob=%0d res=%0d bm=%b expected 1/6/121/1000", valid_o, rob_idx_o, result_o, bmask_o); end
      ready_i = 1'b0;
      br_done_i = 1'b1; br_mispred_i = 1'b1; br_tag_i = 4'b1000;
      step();
      idle();
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL brs_squash_stalled: got %b expected 0", valid_o); end
      ready_i = 1'b1;
      step();
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL brs_after: got %b expected 0", valid_o); end
   endtask

   task automatic test_reset_flush();
      for (int c = 0; c < 3; c++) begin
         drive_op(64'(c + 1), 64'd100, 2'd0, 5'(20 + c), 6'd0, 4'd0);
         step();
      end
      idle();
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rst_mid cyc%0d: got valid=%b rob=%0d expected 0", i, valid_o, rob_idx_o); end
         step();
      end
      drive_op(64'd7, 64'd6, 2'd0, 5'd7, 6'd7, 4'd0);
      step();
      idle();
      step(); step(); step();
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rst_lat_early: got %b expected 0", valid_o); end
      step();
      checks++; if (valid_o !== 1'b1 || rob_idx_o !== 5'd7 || result_o !== 64'd42) begin errors++; $display("FAIL rst_after: got valid=%b rob=%0d res=%0d expected 1/7/42", valid_o, rob_idx_o, result_o); end
      for (int c = 0; c < 3; c++) begin
         drive_op(64'(c + 1), 64'd100, 2'd0, 5'(24 + c), 6'd0, 4'd0);
         step();
      end
      // Op presented alongside the flush is dropped; ready_o stays high.
      drive_op(64'd5, 64'd5, 2'd0, 5'd27, 6'd0, 4'd0);
      flush_i = 1'b1;
      #1;
      checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b expected 1", ready_o); end
      step();
      idle();
      for (int i = 0; i < 6; i++) begin
         checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL flush_mid cyc%0d: got valid=%b rob=%0d expected 0", i, valid_o, rob_idx_o); end
         step();
      end
      drive_op(64'd8, 64'd8, 2'd0, 5'd8, 6'd8, 4'd0);
      step();
      idle();
      step(); step(); step();
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL flush_lat_early: got %b expected 0", valid_o); end
      step();
      checks++; if (valid_o !== 1'b1 || rob_idx_o !== 5'd8 || dest_tag_o !== 6'd8 || result_o !== 64'd64) begin errors++; $display("FAIL flush_after: got valid=%b rob=%0d tag=%0d res=%0d expected 1/8/8/64", valid_o, rob_idx_o, dest_tag_o, result_o); end
      step();
   endtask

   initial begin
      reset = 1'b1;
      ready_i = 1'b1;
      idle();
      test_reset();
      test_basic();
      test_back_to_back();
      test_corner();
      test_backpressure();
      test_branch();
      test_branch_accept();
      test_branch_stall();
      test_reset_flush();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
